// File: rtl/ctrl_pipe_fwd.sv
// ctrl_pipe_fwd: decodes one instruction per cycle into a 16-bit control word,
// carries control and register fields down an NSTAGE-deep pipeline, resolves
// RAW forwarding against older stages, stalls on multiply-use hazards and
// flushes on taken branches.
module ctrl_pipe_fwd #(
   parameter int OPW     = 4,
   parameter int RW      = 4,
   parameter int NSTAGE  = 3,
   parameter int MUL_LAT = 2,
   localparam int SW     = $clog2(NSTAGE),
   localparam int IW     = OPW + 3*RW,
   localparam int FW     = 3*RW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inst_valid,
   input  logic [IW-1:0]        inst,
   output logic                 inst_ready,
   input  logic                 br_taken,
   output logic [16*NSTAGE-1:0] ctrl_bus,
   output logic [FW*NSTAGE-1:0] regs_bus,
   output logic [SW-1:0]        fwd_a,
   output logic [SW-1:0]        fwd_b,
   output logic                 stall
);

   localparam int          CW     = (MUL_LAT > 1) ? $clog2(MUL_LAT) + 1 : 1;
   localparam logic [15:0] NOP_CW = 16'h0002;

   // Base control word for an opcode, with the opcode copied into [14:11].
   function automatic logic [15:0] decode(input logic [OPW-1:0] op);
      logic [3:0]  o4;
      logic [15:0] base;
      o4 = 4'(op);
      case (o4)
         4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: base = 16'h0116;
         4'd11:                              base = 16'h0096;
         4'd12:                              base = 16'h0047;
         4'd15:                              base = 16'h0506;
         default:                            base = 16'h0106;
      endcase
      return base | {1'b0, o4, 11'b0};
   endfunction

   // Immediate ops take ULA_B from the immediate path, so rt forwarding
   // must not override their ULA_B select.
   function automatic logic is_imm(input logic [OPW-1:0] op);
      logic [3:0] o4;
      o4 = 4'(op);
      case (o4)
         4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   // A stage is a forwarding source only if it really writes a register.
   function automatic logic writes_reg(input logic [15:0] w);
      return w[8] && (w != 16'h0000) && (w != NOP_CW);
   endfunction

   logic [15:0]   ctrl_p [NSTAGE];
   logic [FW-1:0] regs_p [NSTAGE];
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] cnt_nxt;

   logic [OPW-1:0] in_op;
   logic [RW-1:0]  in_rs;
   logic [RW-1:0]  in_rt;
   logic [RW-1:0]  rd_p0;
   logic           is_nop;
   logic [SW-1:0]  fa;
   logic [SW-1:0]  fb;
   logic [15:0]    dec_ctrl;
   logic           mul_hit;
   logic           hazard;
   logic           load;

   assign in_op  = inst[IW-1 -: OPW];
   assign in_rs  = inst[2*RW-1:RW];
   assign in_rt  = inst[RW-1:0];
   assign rd_p0  = regs_p[0][FW-1 -: RW];
   assign is_nop = (inst == '0);

   // Forward-source search: nearest older stage that writes the source register.
   always_comb begin
      fa = '0;
      fb = '0;
      for (int k = NSTAGE-2; k >= 0; k--) begin
         if (writes_reg(ctrl_p[k]) && (regs_p[k][FW-1 -: RW] == in_rs)) fa = SW'(k+1);
         if (writes_reg(ctrl_p[k]) && (regs_p[k][FW-1 -: RW] == in_rt)) fb = SW'(k+1);
      end
      if (is_nop) begin
         fa = '0;
         fb = '0;
      end
   end

   // Decoded control word with forwarding patches for the ULA operand selects.
   always_comb begin
      dec_ctrl = decode(in_op);
      if (is_nop) begin
         dec_ctrl = NOP_CW;
      end else begin
         if (fa == SW'(1)) begin
            dec_ctrl[9] = 1'b1;
            dec_ctrl[2] = 1'b0;
         end
         if ((fb != '0) && !is_imm(in_op)) dec_ctrl[4:3] = 2'b11;
      end
   end

   // Multiply-use hazard detection, stall counter update and issue decision.
   always_comb begin
      mul_hit = (MUL_LAT > 1) && inst_valid && ctrl_p[0][10] &&
                ((in_rs == rd_p0) || (in_rt == rd_p0));
      hazard  = (stall_cnt != '0) || mul_hit;
      load    = inst_valid && !br_taken && !hazard;
      cnt_nxt = '0;
      if (br_taken)               cnt_nxt = '0;
      else if (stall_cnt != '0)   cnt_nxt = stall_cnt - CW'(1);
      else if (mul_hit)           cnt_nxt = (MUL_LAT > 1) ? CW'(MUL_LAT-2) : '0;
   end

   assign inst_ready = !rst && (br_taken || !hazard);

   // Control pipeline: shift every stage down, load stage 0 with decode or bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSTAGE; k++) begin
            ctrl_p[k] <= '0;
            regs_p[k] <= '0;
         end
         fwd_a     <= '0;
         fwd_b     <= '0;
         stall     <= 1'b0;
         stall_cnt <= '0;
      end else begin
         for (int k = 1; k < NSTAGE; k++) begin
            ctrl_p[k] <= ctrl_p[k-1];
            regs_p[k] <= regs_p[k-1];
         end
         if (load) begin
            ctrl_p[0] <= dec_ctrl;
            regs_p[0] <= inst[FW-1:0];
            fwd_a     <= fa;
            fwd_b     <= fb;
         end else begin
            ctrl_p[0] <= '0;
            regs_p[0] <= '0;
            fwd_a     <= '0;
            fwd_b     <= '0;
         end
         stall     <= hazard && !br_taken;
         stall_cnt <= cnt_nxt;
      end
   end

   // Flatten the stage arrays onto the output buses, stage k at slice k.
   always_comb begin
      ctrl_bus = '0;
      regs_bus = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         ctrl_bus[16*k +: 16] = ctrl_p[k];
         regs_bus[FW*k +: FW] = regs_p[k];
      end
   end

endmodule

// File: tb/tb_ctrl_pipe_fwd.sv
// Randomised scoreboard bench for ctrl_pipe_fwd with a behavioural reference model.
module tb_ctrl_pipe_fwd;

   localparam int OPW     = 4;
   localparam int RW      = 4;
   localparam int NSTAGE  = 4;
   localparam int MUL_LAT = 3;
   localparam int SW      = $clog2(NSTAGE);
   localparam int IW      = OPW + 3*RW;
   localparam int FW      = 3*RW;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 inst_valid = 1'b0;
   logic [IW-1:0]        inst = '0;
   logic                 inst_ready;
   logic                 br_taken = 1'b0;
   logic [16*NSTAGE-1:0] ctrl_bus;
   logic [FW*NSTAGE-1:0] regs_bus;
   logic [SW-1:0]        fwd_a;
   logic [SW-1:0]        fwd_b;
   logic                 stall;

   ctrl_pipe_fwd #(.OPW(OPW), .RW(RW), .NSTAGE(NSTAGE), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
      .inst_ready(inst_ready), .br_taken(br_taken), .ctrl_bus(ctrl_bus),
      .regs_bus(regs_bus), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
   );

   initial forever #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                   due;
      bit                   is_rdy;
      logic                 rdy;
      logic [16*NSTAGE-1:0] ctrl;
      logic [FW*NSTAGE-1:0] regs;
      logic [SW-1:0]        fa;
      logic [SW-1:0]        fb;
      logic                 st;
   } exp_t;

   exp_t sb[$];

   // Reference model: list of in-flight instructions, youngest first.
   logic [15:0]   mc [NSTAGE];
   logic [FW-1:0] mr [NSTAGE];
   int            m_left;
   int            m_fa, m_fb;
   logic          m_st;

   function automatic logic [15:0] ref_word(input logic [15:0] i);
      int op;
      logic [15:0] w;
      op = int'(i[15:12]);
      if (i == 16'h0000) return 16'h0002;
      case (op)
         11:                 w = 16'h0096;
         12:                 w = 16'h0047;
         15:                 w = 16'h0506;
         2, 6, 7, 8, 9, 10:  w = 16'h0116;
         default:            w = 16'h0106;
      endcase
      return w + 16'(op * 2048);
   endfunction

   function automatic bit ref_imm(input int op);
      return (op == 2) || (op >= 6 && op <= 10);
   endfunction

   function automatic bit ref_writer(input logic [15:0] w);
      return (w[8] == 1'b1) && (w != 16'h0000) && (w != 16'h0002);
   endfunction

   task automatic model_step(input logic r, input logic v, input logic b,
                             input logic [15:0] i, output logic rdy);
      logic [15:0]   nc;
      logic [FW-1:0] nr;
      bit            haz;
      int            fa, fb;
      if (r) begin
         rdy = 1'b0;
         for (int k = 0; k < NSTAGE; k++) begin mc[k] = '0; mr[k] = '0; end
         m_left = 0; m_fa = 0; m_fb = 0; m_st = 1'b0;
         return;
      end
      if (m_left == 0 && MUL_LAT > 1 && v && mc[0][10] &&
          (i[7:4] == mr[0][11:8] || i[3:0] == mr[0][11:8]))
         m_left = MUL_LAT - 1;
      haz = (m_left > 0);
      rdy = b || !haz;
      nc = '0; nr = '0; fa = 0; fb = 0;
      if (v && !b && !haz) begin
         nc = ref_word(i);
         nr = i[11:0];
         if (i != 16'h0000) begin
            for (int j = 0; j <= NSTAGE-2; j++) begin
               if (fa == 0 && ref_writer(mc[j]) && mr[j][11:8] == i[7:4]) fa = j + 1;
               if (fb == 0 && ref_writer(mc[j]) && mr[j][11:8] == i[3:0]) fb = j + 1;
            end
            if (fa == 1) begin nc[9] = 1'b1; nc[2] = 1'b0; end
            if (fb != 0 && !ref_imm(int'(i[15:12]))) nc[4:3] = 2'b11;
         end
      end
      for (int k = NSTAGE-1; k >= 1; k--) begin mc[k] = mc[k-1]; mr[k] = mr[k-1]; end
      mc[0] = nc; mr[0] = nr;
      m_fa = fa; m_fb = fb;
      m_st = haz && !b;
      if (b)        m_left = 0;
      else if (haz) m_left = m_left - 1;
   endtask

   // Apply one cycle of stimulus, queue the expected responses, advance past the edge.
   task automatic drive(input logic r, input logic v, input logic b, input logic [15:0] i);
      exp_t e;
      logic rdy;
      rst = r; inst_valid = v; br_taken = b; inst = i;
      model_step(r, v, b, i, rdy);
      e = '{due: cyc, is_rdy: 1'b1, rdy: rdy, ctrl: '0, regs: '0, fa: '0, fb: '0, st: 1'b0};
      sb.push_back(e);
      e.due = cyc + 1; e.is_rdy = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
         e.ctrl[16*k +: 16] = mc[k];
         e.regs[FW*k +: FW] = mr[k];
      end
      e.fa = SW'(m_fa); e.fb = SW'(m_fb); e.st = m_st;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs against queued expectations on the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         if (e.is_rdy) begin
            if (inst_ready !== e.rdy) begin
               n_fail++;
               $display("FAIL inst_ready cyc %0d: got %b expected %b", e.due, inst_ready, e.rdy);
            end
         end else if (ctrl_bus !== e.ctrl || regs_bus !== e.regs || fwd_a !== e.fa ||
                      fwd_b !== e.fb || stall !== e.st) begin
            n_fail++;
            $display("FAIL state cyc %0d: got ctrl=%h regs=%h fa=%0d fb=%0d st=%b expected ctrl=%h regs=%h fa=%0d fb=%0d st=%b",
                     e.due, ctrl_bus, regs_bus, fwd_a, fwd_b, stall,
                     e.ctrl, e.regs, e.fa, e.fb, e.st);
         end
      end
   end

   initial begin
      logic [15:0] ri;
      @(posedge clk);
      #1;
      // Reset, then a plain ALU op.
      drive(1, 0, 0, 16'h0000);
      drive(1, 0, 0, 16'h0000);
      chk("rst_ctrl", 64'(ctrl_bus), 64'h0);
      chk("rst_stall", 64'(stall), 64'h0);
      drive(0, 1, 0, 16'h1123);
      chk("t1_ctrl0", 64'(ctrl_bus[15:0]), 64'h0906);
      chk("t1_regs0", 64'(regs_bus[11:0]), 64'h123);
      chk("t1_older", 64'(ctrl_bus[63:16]), 64'h0);
      chk("t1_fwd", 64'({fwd_a, fwd_b}), 64'h0);
      // rs forwarded from stage 1 into an immediate op.
      drive(1, 0, 0, 16'h0000);
      drive(0, 1, 0, 16'h1312);
      drive(0, 1, 0, 16'h2430);
      chk("t2_fwd_a", 64'(fwd_a), 64'd1);
      chk("t2_ctrl0", 64'(ctrl_bus[15:0]), 64'h1312);
      // NOP in between, rt forwarded from stage 2.
      drive(1, 0, 0, 16'h0000);
      drive(0, 1, 0, 16'h1500);
      drive(0, 1, 0, 16'h0000);
      chk("t3_nop", 64'(ctrl_bus[15:0]), 64'h0002);
      drive(0, 1, 0, 16'h1605);
      chk("t3_fwd_b", 64'(fwd_b), 64'd2);
      chk("t3_ctrl0", 64'(ctrl_bus[15:0]), 64'h091E);
      // Multiply-use hazard: two bubbles, then issue with a deep forward.
      drive(1, 0, 0, 16'h0000);
      drive(0, 1, 0, 16'hF712);
      chk("t4_mul", 64'(ctrl_bus[15:0]), 64'h7D06);
      drive(0, 1, 0, 16'h1870);
      chk("t4_stall1", 64'(stall), 64'd1);
      chk("t4_bubble1", 64'(ctrl_bus[15:0]), 64'h0);
      drive(0, 1, 0, 16'h1870);
      chk("t4_stall2", 64'(stall), 64'd1);
      drive(0, 1, 0, 16'h1870);
      chk("t4_issue", 64'(ctrl_bus[15:0]), 64'h0906);
      chk("t4_fwd_a", 64'(fwd_a), 64'd3);
      chk("t4_nostall", 64'(stall), 64'd0);
      // Branch flush discards a valid instruction.
      drive(0, 1, 0, 16'h1234);
      drive(0, 1, 1, 16'h1111);
      chk("t5_flush", 64'(ctrl_bus[15:0]), 64'h0);
      chk("t5_regs", 64'(regs_bus[11:0]), 64'h0);
      // Reset in the middle of a mul stall.
      drive(1, 0, 0, 16'h0000);
      drive(0, 1, 0, 16'hF712);
      drive(0, 1, 0, 16'h1870);
      drive(1, 1, 0, 16'h1870);
      chk("t6_ctrl", 64'(ctrl_bus), 64'h0);
      chk("t6_stall", 64'(stall), 64'd0);
      drive(0, 1, 0, 16'h1870);
      // Random traffic with a small register space to provoke dependences.
      for (int n = 0; n < 3000; n++) begin
         ri = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
         if ($urandom_range(0, 3) == 0) ri[15:12] = 4'hF;
         if ($urandom_range(0, 31) == 0) ri = 16'h0000;
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) == 0), ri);
      end
      drive(0, 0, 0, 16'h0000);
      drive(0, 0, 0, 16'h0000);
      for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
